// File: rtl/ex_muldiv_ctrl.sv
// Purpose: sequencer for the shared iterative RV32M multiply/divide unit in EX.
// Latency: result pulse 33 cycles after accept (1 cycle on the divide-by-zero early-out path).
// Backpressure: EX_Stall_o holds IF/ID/EX while an op is being accepted or iterating; no input ready.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   ID_Valid_i, ID_Muldiv_op_i        op present in EX, funct3 (MUL..REMU)
//   ID_Read_reg1_i, ID_Read_reg2_i    rs1 / rs2 operands
//   ID_Rd_i                           destination register
//   Flush_i                           abort current or incoming op
//   EX_Stall_o                        pipeline hold
//   EX_Muldiv_valid_o                 one-cycle result pulse (registered)
//   EX_Muldiv_result_o, EX_Rd_o       result and destination (registered, held until next result)
//   Busy_o                            sequencer not idle
module ex_muldiv_ctrl #(
  parameter int EARLY_OUT = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ID_Valid_i,
  input  logic [2:0]  ID_Muldiv_op_i,
  input  logic [31:0] ID_Read_reg1_i,
  input  logic [31:0] ID_Read_reg2_i,
  input  logic [4:0]  ID_Rd_i,
  input  logic        Flush_i,
  output logic        EX_Stall_o,
  output logic        EX_Muldiv_valid_o,
  output logic [31:0] EX_Muldiv_result_o,
  output logic [4:0]  EX_Rd_o,
  output logic        Busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [2:0]  op_q;
  logic [4:0]  rd_q;
  logic [31:0] rs1_q;
  logic [31:0] b_q;      // multiplicand or divisor magnitude
  logic [63:0] p_q;      // mul: {partial hi, multiplier}; div: {partial rem, dividend/quotient}
  logic        neg_a_q;
  logic        neg_b_q;
  logic        dz_q;

  // ---------------------------------------------------------------
  // Incoming op decode
  // ---------------------------------------------------------------
  logic        accept;
  logic        in_a_signed;
  logic        in_b_signed;
  logic        in_neg_a;
  logic        in_neg_b;
  logic [31:0] in_a_mag;
  logic [31:0] in_b_mag;
  logic        in_dz;
  logic        early;
  logic [31:0] early_res;

  assign accept = ((state == IDLE) || (state == DONE)) && ID_Valid_i && !Flush_i;

  // MULH, MULHSU, DIV, REM treat rs1 as signed; MULHSU keeps rs2 unsigned.
  assign in_a_signed = (ID_Muldiv_op_i == 3'd1) || (ID_Muldiv_op_i == 3'd2) ||
                       (ID_Muldiv_op_i == 3'd4) || (ID_Muldiv_op_i == 3'd6);
  assign in_b_signed = (ID_Muldiv_op_i == 3'd1) || (ID_Muldiv_op_i == 3'd4) ||
                       (ID_Muldiv_op_i == 3'd6);

  assign in_neg_a = in_a_signed && ID_Read_reg1_i[31];
  assign in_neg_b = in_b_signed && ID_Read_reg2_i[31];
  assign in_a_mag = in_neg_a ? (~ID_Read_reg1_i + 32'd1) : ID_Read_reg1_i;
  assign in_b_mag = in_neg_b ? (~ID_Read_reg2_i + 32'd1) : ID_Read_reg2_i;
  assign in_dz    = (ID_Read_reg2_i == 32'd0);

  assign early     = (EARLY_OUT != 0) && ID_Muldiv_op_i[2] && in_dz;
  // op[1] selects remainder (REM/REMU) over quotient (DIV/DIVU)
  assign early_res = ID_Muldiv_op_i[1] ? ID_Read_reg1_i : 32'hFFFF_FFFF;

  // ---------------------------------------------------------------
  // One iteration step
  // ---------------------------------------------------------------
  logic [32:0] mul_sum;
  logic [32:0] div_part;
  logic        div_ge;
  logic [31:0] div_rem;
  logic [63:0] p_next;

  // Shift-add: add multiplicand into the high half when the current
  // multiplier LSB is set, then shift the whole 65-bit value right.
  assign mul_sum = {1'b0, p_q[63:32]} + ({1'b0, b_q} & {33{p_q[0]}});

  // Restoring divide: partial remainder shifted left with the next dividend
  // bit; it can need 33 bits before the compare. After a successful subtract
  // the result is below the divisor, so 32 bits hold it.
  assign div_part = p_q[63:31];
  assign div_ge   = (div_part >= {1'b0, b_q});
  assign div_rem  = div_part[31:0] - b_q;

  always_comb begin
    p_next = p_q;
    if (op_q[2]) begin
      if (div_ge) p_next = {div_rem, p_q[30:0], 1'b1};
      else        p_next = {p_q[62:0], 1'b0};
    end else begin
      p_next = {mul_sum, p_q[31:1]};
    end
  end

  // ---------------------------------------------------------------
  // Final sign correction and result select (from the last step's output)
  // ---------------------------------------------------------------
  logic        res_neg;
  logic [63:0] prod;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [31:0] final_res;

  assign res_neg = neg_a_q ^ neg_b_q;
  assign prod    = res_neg ? (~p_next + 64'd1) : p_next;
  assign quot    = res_neg ? (~p_next[31:0] + 32'd1) : p_next[31:0];
  // remainder takes the dividend's sign
  assign rem     = neg_a_q ? (~p_next[63:32] + 32'd1) : p_next[63:32];

  always_comb begin
    final_res = 32'd0;
    case (op_q)
      3'd0:                final_res = prod[31:0];
      3'd1, 3'd2, 3'd3:    final_res = prod[63:32];
      3'd4, 3'd5:          final_res = dz_q ? 32'hFFFF_FFFF : quot;
      default:             final_res = dz_q ? rs1_q : rem;
    endcase
  end

  // ---------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state              <= IDLE;
      cnt                <= 5'd0;
      op_q               <= 3'd0;
      rd_q               <= 5'd0;
      rs1_q              <= 32'd0;
      b_q                <= 32'd0;
      p_q                <= 64'd0;
      neg_a_q            <= 1'b0;
      neg_b_q            <= 1'b0;
      dz_q               <= 1'b0;
      EX_Muldiv_valid_o  <= 1'b0;
      EX_Muldiv_result_o <= 32'd0;
      EX_Rd_o            <= 5'd0;
    end else begin
      EX_Muldiv_valid_o <= 1'b0;
      if (Flush_i) begin
        // abort wins over accept and over completion; no pulse
        state <= IDLE;
        cnt   <= 5'd0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (accept) begin
              op_q    <= ID_Muldiv_op_i;
              rd_q    <= ID_Rd_i;
              rs1_q   <= ID_Read_reg1_i;
              b_q     <= in_b_mag;
              p_q     <= {32'd0, in_a_mag};
              neg_a_q <= in_neg_a;
              neg_b_q <= in_neg_b;
              dz_q    <= in_dz;
              cnt     <= 5'd0;
              if (early) begin
                state              <= DONE;
                EX_Muldiv_valid_o  <= 1'b1;
                EX_Muldiv_result_o <= early_res;
                EX_Rd_o            <= ID_Rd_i;
              end else begin
                state <= CALC;
              end
            end else begin
              state <= IDLE;
            end
          end
          CALC: begin
            p_q <= p_next;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              state              <= DONE;
              EX_Muldiv_valid_o  <= 1'b1;
              EX_Muldiv_result_o <= final_res;
              EX_Rd_o            <= rd_q;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= 5'd0;
          end
        endcase
      end
    end
  end

  assign EX_Stall_o = accept || (state == CALC);
  assign Busy_o     = (state != IDLE);

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Testbench for ex_muldiv_ctrl: directed vector table, hand-written multi-cycle
// sequences (flush, reset mid-op, back-to-back), and randomized ops checked
// against an arithmetic reference model.
module tb_ex_muldiv_ctrl;

  logic        clk;
  logic        rst;
  logic        vld;
  logic [2:0]  op;
  logic [31:0] r1;
  logic [31:0] r2;
  logic [4:0]  rd;
  logic        flush;
  logic        stall;
  logic        mvld;
  logic [31:0] res;
  logic [4:0]  rdo;
  logic        busy;

  int checks;
  int errors;

  ex_muldiv_ctrl #(.EARLY_OUT(1)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .ID_Valid_i         (vld),
    .ID_Muldiv_op_i     (op),
    .ID_Read_reg1_i     (r1),
    .ID_Read_reg2_i     (r2),
    .ID_Rd_i            (rd),
    .Flush_i            (flush),
    .EX_Stall_o         (stall),
    .EX_Muldiv_valid_o  (mvld),
    .EX_Muldiv_result_o (res),
    .EX_Rd_o            (rdo),
    .Busy_o             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  // Reference model: plain 64-bit / signed arithmetic plus the RISC-V corner rules.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ub;
    logic [63:0] pr;
    int          ia;
    int          ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    ia = a;
    ib = b;
    pr = 64'd0;
    case (f)
      3'd0: begin pr = {32'd0, a} * {32'd0, b}; return pr[31:0]; end
      3'd1: begin pr = sa * sb; return pr[63:32]; end
      3'd2: begin pr = sa * ub; return pr[63:32]; end
      3'd3: begin pr = {32'd0, a} * {32'd0, b}; return pr[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] b);
    return (f[2] && b == 32'd0) ? 1 : 33;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // advance one cycle; inputs are changed and outputs sampled at the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic present(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
    op = f;
    r1 = a;
    r2 = b;
    rd = d;
    vld = 1'b1;
  endtask

  // Issue one op from IDLE and follow it through to its result.
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] d,
                        input logic [31:0] exp, input int exp_lat);
    int   lat;
    logic stall_ok;
    logic [31:0] held;
    present(f, a, b, d);
    #1;
    chk1({name, "_stall_accept"}, stall, 1'b1);
    tick();
    vld = 1'b0;
    #1;
    lat = 1;
    stall_ok = 1'b1;
    while (!mvld && lat < 40) begin
      if (!stall || !busy) stall_ok = 1'b0;
      tick();
      lat++;
    end
    chk1({name, "_stall_calc"}, stall_ok, 1'b1);
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_result"}, res, exp);
    chk({name, "_rd"}, {27'd0, rdo}, {27'd0, d});
    chk1({name, "_done_stall"}, stall, 1'b0);
    held = res;
    tick();
    chk1({name, "_pulse_one_cycle"}, mvld, 1'b0);
    chk({name, "_result_held"}, res, held);
    chk1({name, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    int   lat;
    int   seen;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  d;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    vld = 1'b0;
    flush = 1'b0;
    op = 3'd0;
    r1 = 32'd0;
    r2 = 32'd0;
    rd = 5'd0;

    vecs[0]  = '{3'd0, 32'd7,          32'd6,          5'd5,  32'd42,         33};
    vecs[1]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'h0000_0000,  33};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'hFFFF_FFFE,  33};
    vecs[3]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFD,  33};
    vecs[4]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFF,  33};
    vecs[5]  = '{3'd5, 32'd100,        32'd0,          5'd6,  32'hFFFF_FFFF,  1};
    vecs[6]  = '{3'd7, 32'd100,        32'd0,          5'd7,  32'd100,        1};
    vecs[7]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  5'd8,  32'h8000_0000,  33};
    vecs[8]  = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  32'd0,          33};
    vecs[9]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd10, 32'hFFFF_FFFF,  33};
    vecs[10] = '{3'd4, 32'd7,          32'd0,          5'd11, 32'hFFFF_FFFF,  1};
    vecs[11] = '{3'd6, 32'hFFFF_FFFB,  32'd0,          5'd12, 32'hFFFF_FFFB,  1};
    vecs[12] = '{3'd4, 32'd20,         32'hFFFF_FFFD,  5'd13, 32'hFFFF_FFFA,  33};
    vecs[13] = '{3'd6, 32'd20,         32'hFFFF_FFFD,  5'd14, 32'd2,          33};
    vecs[14] = '{3'd7, 32'd10,         32'd3,          5'd15, 32'd1,          33};
    vecs[15] = '{3'd1, 32'h8000_0000,  32'h8000_0000,  5'd31, 32'h4000_0000,  33};

    @(negedge clk);
    tick();
    tick();
    chk1("reset_valid", mvld, 1'b0);
    chk("reset_result", res, 32'd0);
    chk("reset_rd", {27'd0, rdo}, 32'd0);
    chk1("reset_stall", stall, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    rst = 1'b0;
    tick();

    // directed vectors
    for (int i = 0; i < 16; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
             vecs[i].exp, vecs[i].lat);
    end

    // flush at T+10 of a DIV: idle at T+11 and no pulse afterwards
    present(3'd4, 32'd1000, 32'd7, 5'd20);
    tick();
    vld = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk1("flush_busy", busy, 1'b0);
    chk1("flush_stall", stall, 1'b0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (mvld) seen++;
      tick();
    end
    chk("flush_no_pulse", seen, 0);

    // flush beats a simultaneous accept
    present(3'd0, 32'd3, 32'd4, 5'd21);
    flush = 1'b1;
    #1;
    chk1("flush_accept_stall", stall, 1'b0);
    tick();
    vld = 1'b0;
    flush = 1'b0;
    #1;
    chk1("flush_accept_busy", busy, 1'b0);
    tick();

    // reset at T+5 of an op clears everything; next op completes normally
    present(3'd0, 32'd9, 32'd9, 5'd22);
    tick();
    vld = 1'b0;
    for (int i = 1; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("midrst_valid", mvld, 1'b0);
    chk("midrst_result", res, 32'd0);
    chk("midrst_rd", {27'd0, rdo}, 32'd0);
    chk1("midrst_stall", stall, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (mvld) seen++;
      tick();
    end
    chk("midrst_no_pulse", seen, 0);
    run_op("after_rst", 3'd0, 32'd7, 32'd6, 5'd5, 32'd42, 33);

    // back-to-back: next op held on ID during CALC, accepted in the DONE cycle
    present(3'd0, 32'd7, 32'd6, 5'd5);
    tick();
    present(3'd5, 32'd100, 32'd7, 5'd9);
    #1;
    lat = 1;
    while (!mvld && lat < 40) begin
      tick();
      lat++;
    end
    chk("b2b_first_latency", lat, 33);
    chk("b2b_first_result", res, 32'd42);
    chk("b2b_first_rd", {27'd0, rdo}, 32'd5);
    chk1("b2b_done_stall", stall, 1'b1);
    tick();
    vld = 1'b0;
    #1;
    chk1("b2b_second_calc", busy && stall && !mvld, 1'b1);
    lat = 1;
    while (!mvld && lat < 40) begin
      tick();
      lat++;
    end
    chk("b2b_second_latency", lat, 33);
    chk("b2b_second_result", res, 32'd14);
    chk("b2b_second_rd", {27'd0, rdo}, 32'd9);
    tick();

    // randomized ops against the reference model
    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: a = 32'd0;
        1: a = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: a = 32'($urandom_range(0, 20));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'h8000_0000;
        3: b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      d = 5'($urandom_range(0, 31));
      run_op($sformatf("rand%0d_op%0d", i, f), f, a, b, d, model(f, a, b), model_lat(f, b));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_ctrl.md
EX_MULDIV_CTRL -- requirements
Module: ex_muldiv_ctrl

Sequencer for the shared iterative RV32M multiply/divide resource in EX. Accepts one op from ID, stalls the pipeline while iterating, returns one result.

Interface
REQ-001 Parameter: EARLY_OUT, default 1, meaning: 1 enables the single-cycle divide-by-zero path.
REQ-002 clk_i  in  1  clock; all state updates on the rising edge.
REQ-003 rst_i  in  1  reset; synchronous, active-high.
REQ-004 ID_Valid_i  in  1  M-extension op present in EX this cycle.
REQ-005 ID_Muldiv_op_i  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 ID_Read_reg1_i, ID_Read_reg2_i  in  32 each  rs1 and rs2 operands.
REQ-007 ID_Rd_i  in  5  destination register.
REQ-008 Flush_i  in  1  abort the current or incoming op.
REQ-009 EX_Stall_o  out  1  hold the IF/ID/EX pipeline registers.
REQ-010 EX_Muldiv_valid_o  out  1  one-cycle result pulse.
REQ-011 EX_Muldiv_result_o  out  32  result.
REQ-012 EX_Rd_o  out  5  destination of the result.
REQ-013 Busy_o  out  1  state is not IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, CALC and DONE; the state register SHALL be the only source of sequencing.
REQ-015 Accept condition: state is IDLE or DONE, ID_Valid_i=1 and Flush_i=0. On accept, the block SHALL latch the operands, op and rd, and SHALL move to CALC.
REQ-016 With EARLY_OUT=1, a div/rem op with rs2=0 SHALL move directly to DONE.
REQ-017 CALC SHALL run exactly 32 iterations, counted by a 5-bit counter; 1 bit per cycle, shift-add for multiply and restoring for divide.
REQ-018 After the 32nd iteration, the FSM SHALL move to DONE; DONE SHALL move to IDLE unless a new accept occurs.
REQ-019 Latency: an op accepted at cycle T SHALL produce EX_Muldiv_valid_o=1 at cycle T+33, or at T+1 on the early-out path.
REQ-020 EX_Stall_o = (accept-eligible state AND ID_Valid_i AND NOT Flush_i) OR state==CALC. It SHALL be 0 in DONE when no new op is presented.
REQ-021 Signed ops (MULH/MULHSU/DIV/REM) SHALL operate on magnitudes and negate the result per operand signs. MULHSU treats rs1 as signed and rs2 as unsigned.
REQ-022 MUL SHALL return product[31:0]; MULH, MULHSU and MULHU SHALL return product[63:32] of the full 64-bit product.
REQ-023 Divide by zero: quotient SHALL be 0xFFFFFFFF and remainder SHALL be rs1, for signed and unsigned ops.
REQ-024 Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV SHALL return 0x80000000 and REM SHALL return 0.
REQ-025 Remainder sign SHALL follow the dividend; quotient SHALL truncate toward zero.
REQ-026 EX_Muldiv_result_o and EX_Rd_o SHALL be registered and held stable from the DONE cycle until the next DONE.
REQ-027 ID_Valid_i during CALC SHALL be ignored; the instruction is held by EX_Stall_o.
REQ-028 Flush_i=1 in any state SHALL force IDLE on the next edge with no valid pulse. Flush wins over a simultaneous accept.
REQ-029 Back-to-back: an accept in DONE SHALL still produce the DONE-cycle pulse for the prior op and SHALL start the new op in CALC on the next edge.

Reset
REQ-030 rst_i=1 at any edge, including mid-CALC, SHALL force state=IDLE and counter=0.
REQ-031 On reset, EX_Muldiv_valid_o, EX_Muldiv_result_o, EX_Rd_o, EX_Stall_o and Busy_o SHALL be 0; the in-flight op is discarded.
REQ-032 rst_i SHALL take priority over Flush_i and ID_Valid_i.

Verification
REQ-033 MUL 7 x 6, rd=5, accepted at T -> stall during T..T+32, valid at T+33, result 42, rd 5.
REQ-034 MULH 0xFFFFFFFF x 0xFFFFFFFF -> result 0x00000000; MULHU on the same operands -> 0xFFFFFFFE.
REQ-035 DIV -7 / 2 -> 0xFFFFFFFD; REM -7 % 2 -> 0xFFFFFFFF.
REQ-036 DIVU 100 / 0 with EARLY_OUT=1 -> valid at T+1, result 0xFFFFFFFF. REMU 100 % 0 -> 100.
REQ-037 DIV 0x80000000 / -1 -> 0x80000000; REM -> 0.
REQ-038 Flush_i at T+10 of a DIV -> IDLE at T+11, no valid pulse. rst_i at T+5 of a new op -> all outputs 0 next cycle, and a fresh op then completes normally.
